// File: rtl/mapping_hash_pkg.sv
// mapping_hash_pkg: shared definitions for the mapping hash responder.
//   - bit offsets of the tag / VPN / PPN / hit fields in the 72-bit streams
//   - insert status codes
//   - responder FSM state encoding
//   - hash_fold(): XOR-fold of a VPN down to a bucket index
package mapping_hash_pkg;

  localparam int TAG_LSB    = 64;
  localparam int TAG_W      = 8;
  localparam int HIT_BIT    = 63;
  localparam int WR_VPN_LSB = 32;

  localparam logic [1:0] ST_INSERTED = 2'd0;
  localparam logic [1:0] ST_UPDATED  = 2'd1;
  localparam logic [1:0] ST_FULL     = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CMP  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Cut the VPN into idx_w-bit chunks from the LSB up and XOR them together.
  // The top chunk is implicitly zero-padded because bits above bit 31 shift
  // in as zero. Only the low idx_w bits of the result are meaningful.
  function automatic logic [31:0] hash_fold(input logic [31:0] vpn, input int idx_w);
    logic [31:0] acc;
    logic [31:0] mask;
    acc  = '0;
    mask = (32'd1 << idx_w) - 32'd1;
    for (int s = 0; s < 32; s += idx_w)
      acc = acc ^ ((vpn >> s) & mask);
    return acc;
  endfunction

endpackage

// File: rtl/mapping_hash_bucket_ram.sv
// mapping_hash_bucket_ram: NR_BUCKETS x NR_WAYS entry store, entry = {vpn, ppn}.
// One RAM column per way so a single way can be rewritten without touching
// its neighbours. Read is synchronous (data one cycle after rd_addr).
//   clk      clock
//   rd_addr  bucket to read; all ways returned on rd_data next cycle
//   rd_data  [NR_WAYS-1:0][ENTRY_W-1:0] entries of the addressed bucket
//   wr_addr  bucket to write
//   wr_en    one-hot (or zero) per-way write enable
//   wr_data  entry written into every enabled way
module mapping_hash_bucket_ram #(
  parameter int NR_BUCKETS = 64,
  parameter int NR_WAYS    = 4,
  parameter int ENTRY_W    = 64,
  parameter int IDX_W      = $clog2(NR_BUCKETS)
) (
  input  logic                              clk,
  input  logic [IDX_W-1:0]                  rd_addr,
  output logic [NR_WAYS-1:0][ENTRY_W-1:0]   rd_data,
  input  logic [IDX_W-1:0]                  wr_addr,
  input  logic [NR_WAYS-1:0]                wr_en,
  input  logic [ENTRY_W-1:0]                wr_data
);

  for (genvar w = 0; w < NR_WAYS; w++) begin : g_way
    logic [ENTRY_W-1:0] mem [NR_BUCKETS];
    logic [ENTRY_W-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (wr_en[w]) mem[wr_addr] <= wr_data;
      rd_q <= mem[rd_addr];
    end

    assign rd_data[w] = rd_q;
  end

endmodule

// File: rtl/mapping_hash_responder.sv
// mapping_hash_responder: services lookup (read) and insert/update (write)
// requests against an on-chip hashed page table, one request at a time.
// Accept in cycle C -> RAM read (C+1) -> compare/table write (C+2) ->
// response valid from C+3, held until the consumer takes it.
//   clk, rst_n                 clock, async active-low reset
//   in_read_*                  lookup requests  {tag[71:64], vpn[VPN_W-1:0]}
//   in_write_*                 insert requests  {tag, vpn[32+:VPN_W], ppn}
//   out_read_*                 lookup responses {tag, hit[63], ppn}
//   out_write_*                insert responses {tag, status[1:0]}
//   stat_hits/misses/full      saturating counters, only when
//                              MAPPING_HASH_STATS_EN is defined
module mapping_hash_responder
  import mapping_hash_pkg::*;
#(
  parameter int NR_BUCKETS = 64,
  parameter int NR_WAYS    = 4,
  parameter int VPN_W      = 32,
  parameter int PPN_W      = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [71:0] in_read_tdata,
  input  logic        in_read_tvalid,
  output logic        in_read_tready,
  input  logic [71:0] in_write_tdata,
  input  logic        in_write_tvalid,
  output logic        in_write_tready,
  output logic [71:0] out_read_tdata,
  output logic        out_read_tvalid,
  input  logic        out_read_tready,
  output logic [71:0] out_write_tdata,
  output logic        out_write_tvalid,
  input  logic        out_write_tready
`ifdef MAPPING_HASH_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses,
  output logic [31:0] stat_full
`endif
);

  localparam int IDX_W   = $clog2(NR_BUCKETS);
  localparam int ENTRY_W = VPN_W + PPN_W;

  state_t                               state;
  logic                                 prio_wr;   // 1: write wins a contested grant
  logic                                 is_wr;
  logic [TAG_W-1:0]                     req_tag;
  logic [VPN_W-1:0]                     req_vpn;
  logic [PPN_W-1:0]                     req_ppn;
  logic [IDX_W-1:0]                     bucket_q;
  logic [NR_BUCKETS-1:0][NR_WAYS-1:0]   valid_q;

  logic                                 grant_wr, grant_rd;
  logic [VPN_W-1:0]                     sel_vpn;
  logic [IDX_W-1:0]                     sel_bucket;
  logic [NR_WAYS-1:0][ENTRY_W-1:0]      rd_data;
  logic [NR_WAYS-1:0]                   way_vld, match, free_low, way_sel, way_we;
  logic [PPN_W-1:0]                     hit_ppn;
  logic [1:0]                           wr_status;
  logic [71:0]                          rd_resp, wr_resp;
  logic                                 unused_bits;

  // Unused request bits are don't-care by definition.
  assign unused_bits = ^{in_read_tdata, in_write_tdata};

  // Grant logic is combinational so that only the winner sees tready.
  assign grant_wr = (state == S_IDLE) && in_write_tvalid && (!in_read_tvalid || prio_wr);
  assign grant_rd = (state == S_IDLE) && in_read_tvalid && (!in_write_tvalid || !prio_wr);
  assign in_write_tready = grant_wr;
  assign in_read_tready  = grant_rd;

  assign sel_vpn    = grant_wr ? in_write_tdata[WR_VPN_LSB +: VPN_W] : in_read_tdata[VPN_W-1:0];
  assign sel_bucket = IDX_W'(hash_fold(32'(sel_vpn), IDX_W));

  mapping_hash_bucket_ram #(
    .NR_BUCKETS (NR_BUCKETS),
    .NR_WAYS    (NR_WAYS),
    .ENTRY_W    (ENTRY_W),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk     (clk),
    .rd_addr (bucket_q),
    .rd_data (rd_data),
    .wr_addr (bucket_q),
    .wr_en   (way_we),
    .wr_data ({req_vpn, req_ppn})
  );

  // Compare stage: all ways in parallel. A VPN lives in at most one way,
  // so the PPN mux can simply OR the matching entries.
  always_comb begin
    way_vld = valid_q[bucket_q];
    match   = '0;
    hit_ppn = '0;
    for (int w = 0; w < NR_WAYS; w++) begin
      match[w] = way_vld[w] && (rd_data[w][PPN_W +: VPN_W] == req_vpn);
      if (match[w]) hit_ppn = hit_ppn | rd_data[w][PPN_W-1:0];
    end
    // lowest clear bit of the valid mask (zero when the bucket is full)
    free_low = ~way_vld & (way_vld + NR_WAYS'(1));

    // Match is checked first so an insert never duplicates a VPN.
    if (|match) begin
      wr_status = ST_UPDATED;
      way_sel   = match;
    end else if (|free_low) begin
      wr_status = ST_INSERTED;
      way_sel   = free_low;
    end else begin
      wr_status = ST_FULL;
      way_sel   = '0;
    end
    way_we = (state == S_CMP && is_wr) ? way_sel : '0;

    rd_resp                    = '0;
    rd_resp[TAG_LSB +: TAG_W]  = req_tag;
    rd_resp[HIT_BIT]           = |match;
    rd_resp[PPN_W-1:0]         = hit_ppn;

    wr_resp                    = '0;
    wr_resp[TAG_LSB +: TAG_W]  = req_tag;
    wr_resp[1:0]               = wr_status;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      prio_wr          <= 1'b1;
      is_wr            <= 1'b0;
      req_tag          <= '0;
      req_vpn          <= '0;
      req_ppn          <= '0;
      bucket_q         <= '0;
      valid_q          <= '0;
      out_read_tdata   <= '0;
      out_read_tvalid  <= 1'b0;
      out_write_tdata  <= '0;
      out_write_tvalid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_wr || grant_rd) begin
            state    <= S_RD;
            is_wr    <= grant_wr;
            req_tag  <= grant_wr ? in_write_tdata[TAG_LSB +: TAG_W] : in_read_tdata[TAG_LSB +: TAG_W];
            req_vpn  <= sel_vpn;
            req_ppn  <= in_write_tdata[PPN_W-1:0];
            bucket_q <= sel_bucket;
            if (in_read_tvalid && in_write_tvalid) prio_wr <= ~prio_wr;
          end
        end
        S_RD: state <= S_CMP;
        S_CMP: begin
          valid_q[bucket_q] <= valid_q[bucket_q] | way_we;
          if (is_wr) begin
            out_write_tdata  <= wr_resp;
            out_write_tvalid <= 1'b1;
          end else begin
            out_read_tdata   <= rd_resp;
            out_read_tvalid  <= 1'b1;
          end
          state <= S_RESP;
        end
        S_RESP: begin
          if ((out_read_tvalid && out_read_tready) || (out_write_tvalid && out_write_tready)) begin
            out_read_tvalid  <= 1'b0;
            out_write_tvalid <= 1'b0;
            state            <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MAPPING_HASH_STATS_EN
  // Counters advance on the response handshake, not when it is produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_full   <= '0;
    end else begin
      if (out_read_tvalid && out_read_tready) begin
        if (out_read_tdata[HIT_BIT]) begin
          if (stat_hits != '1) stat_hits <= stat_hits + 32'd1;
        end else begin
          if (stat_misses != '1) stat_misses <= stat_misses + 32'd1;
        end
      end
      if (out_write_tvalid && out_write_tready && out_write_tdata[1:0] == ST_FULL)
        if (stat_full != '1) stat_full <= stat_full + 32'd1;
    end
  end
`endif

endmodule
